// File: rtl/time_pkg.sv
// Shared field widths, limits and helpers for the world-clock time base.
// Holds the 24 h counter limits plus the step and 12 h view functions.
package time_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX     = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX     = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX    = 5'd23;
    localparam logic [HOUR_W-1:0] HOUR12_NOON = 5'd12;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } time_t;

    // Which single update wins this cycle, highest priority first.
    typedef enum logic [2:0] {
        UPD_HOLD,
        UPD_LOAD,
        UPD_ADJ_MIN,
        UPD_ADJ_HOUR,
        UPD_TICK
    } upd_t;

    function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] v,
                                                  input logic dec);
        if (dec) begin
            return (v == '0) ? MIN_MAX : v - 6'd1;
        end
        return (v >= MIN_MAX) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] v,
                                                    input logic dec);
        if (dec) begin
            return (v == '0) ? HOUR_MAX : v - 5'd1;
        end
        return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
        if (h == '0 || h == HOUR12_NOON) begin
            return HOUR12_NOON;
        end
        if (h > HOUR12_NOON) begin
            return h - HOUR12_NOON;
        end
        return h;
    endfunction

endpackage

// File: rtl/tb_prescaler.sv
// Clock prescaler for the time base: counts 0..CLK_DIV-1 while enabled.
// wrap_p marks the cycle the count sits on its last value; clr forces the count to 0.
module tb_prescaler #(
    parameter int CLK_DIV = 1000,
    parameter int DIV_W   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap_p
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // clr wins over counting so a load always restarts a full second.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wrap_p = en && (count_q == LAST);

endmodule

// File: rtl/time_base_gen.sv
// 24 h time base with pause, adjust, load, 12/24 h display view and strobes.
// Optional alarm compiled in with `define TIME_BASE_GEN_ALARM_EN.
module time_base_gen
    import time_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int DIV_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic              adj_min_p,
    input  logic              adj_hour_p,
    input  logic              adj_dec,
    input  logic              load,
    input  logic [SEC_W-1:0]  ld_sec,
    input  logic [MIN_W-1:0]  ld_min,
    input  logic [HOUR_W-1:0] ld_hour,
    input  logic              mode_12h,
`ifdef TIME_BASE_GEN_ALARM_EN
    input  logic [HOUR_W-1:0] al_hour,
    input  logic [MIN_W-1:0]  al_min,
    input  logic              al_arm,
    input  logic              al_ack,
    output logic              alarm_active,
`endif
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] disp_hour,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_wrap
);

    logic  wrap_p;
    upd_t  upd;
    time_t time_q;
    time_t time_d;
    logic  sec_tick_q;
    logic  day_wrap_q;
    logic  day_wrap_d;

    tb_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_en),
        .clr    (load),
        .wrap_p (wrap_p)
    );

    // A tick that collides with load/adjust is swallowed here, but sec_tick
    // below still follows wrap_p so downstream sees a steady 1 Hz strobe.
    always_comb begin
        if (load) begin
            upd = UPD_LOAD;
        end else if (adj_min_p) begin
            upd = UPD_ADJ_MIN;
        end else if (adj_hour_p) begin
            upd = UPD_ADJ_HOUR;
        end else if (wrap_p) begin
            upd = UPD_TICK;
        end else begin
            upd = UPD_HOLD;
        end
    end

    always_comb begin
        time_d     = time_q;
        day_wrap_d = 1'b0;
        case (upd)
            UPD_LOAD: begin
                time_d.sec  = (ld_sec  > SEC_MAX)  ? '0 : ld_sec;
                time_d.min  = (ld_min  > MIN_MAX)  ? '0 : ld_min;
                time_d.hour = (ld_hour > HOUR_MAX) ? '0 : ld_hour;
            end
            UPD_ADJ_MIN: begin
                time_d.min = step_min(time_q.min, adj_dec);
            end
            UPD_ADJ_HOUR: begin
                time_d.hour = step_hour(time_q.hour, adj_dec);
            end
            UPD_TICK: begin
                if (time_q.sec >= SEC_MAX) begin
                    time_d.sec = '0;
                    if (time_q.min >= MIN_MAX) begin
                        time_d.min  = '0;
                        time_d.hour = step_hour(time_q.hour, 1'b0);
                        day_wrap_d  = (time_q.hour >= HOUR_MAX);
                    end else begin
                        time_d.min = time_q.min + 6'd1;
                    end
                end else begin
                    time_d.sec = time_q.sec + 6'd1;
                end
            end
            default: begin
                time_d = time_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            time_q     <= time_d;
            sec_tick_q <= wrap_p;
            day_wrap_q <= day_wrap_d;
        end
    end

`ifdef TIME_BASE_GEN_ALARM_EN
    logic alarm_q;
    logic alarm_d;
    logic al_hit;

    // Only a real tick can fire the alarm; clearing beats setting.
    always_comb begin
        al_hit  = (upd == UPD_TICK) && al_arm &&
                  (time_d.hour == al_hour) && (time_d.min == al_min) &&
                  (time_d.sec == '0);
        alarm_d = alarm_q | al_hit;
        if (al_ack || !al_arm) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_active = alarm_q;
`endif

    assign sec       = time_q.sec;
    assign min       = time_q.min;
    assign hour      = time_q.hour;
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign pm        = (time_q.hour >= HOUR12_NOON);
    assign disp_hour = mode_12h ? to_12h(time_q.hour) : time_q.hour;

endmodule

// File: tb/tb_time_base_gen.sv
// Self-checking bench for time_base_gen with CLK_DIV = 4.
// Alarm checks run only when TIME_BASE_GEN_ALARM_EN is defined.
module tb_time_base_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       adj_min_p;
    logic       adj_hour_p;
    logic       adj_dec;
    logic       load;
    logic [5:0] ld_sec;
    logic [5:0] ld_min;
    logic [4:0] ld_hour;
    logic       mode_12h;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] disp_hour;
    logic       pm;
    logic       sec_tick;
    logic       day_wrap;
`ifdef TIME_BASE_GEN_ALARM_EN
    logic [4:0] al_hour;
    logic [5:0] al_min;
    logic       al_arm;
    logic       al_ack;
    logic       alarm_active;
`endif

    int checks   = 0;
    int failures = 0;

    time_base_gen #(
        .CLK_DIV (4),
        .DIV_W   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .adj_min_p    (adj_min_p),
        .adj_hour_p   (adj_hour_p),
        .adj_dec      (adj_dec),
        .load         (load),
        .ld_sec       (ld_sec),
        .ld_min       (ld_min),
        .ld_hour      (ld_hour),
        .mode_12h     (mode_12h),
`ifdef TIME_BASE_GEN_ALARM_EN
        .al_hour      (al_hour),
        .al_min       (al_min),
        .al_arm       (al_arm),
        .al_ack       (al_ack),
        .alarm_active (alarm_active),
`endif
        .sec          (sec),
        .min          (min),
        .hour         (hour),
        .disp_hour    (disp_hour),
        .pm           (pm),
        .sec_tick     (sec_tick),
        .day_wrap     (day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ldH;
        int ldM;
        int ldS;
        int mode;
        int expH;
        int expM;
        int expS;
        int expDisp;
        int expPm;
    } vec_t;

    vec_t vecs[10];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkTime(input string name, input int h, input int m, input int s);
        checkOutput({name, ".hour"}, int'(hour), h);
        checkOutput({name, ".min"}, int'(min), m);
        checkOutput({name, ".sec"}, int'(sec), s);
    endtask

    task automatic applyStimulus(input int h, input int m, input int s);
        ld_hour = 5'(h);
        ld_min  = 6'(m);
        ld_sec  = 6'(s);
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    initial begin
        int ticks;
        rst        = 1'b1;
        tick_en    = 1'b1;
        adj_min_p  = 1'b0;
        adj_hour_p = 1'b0;
        adj_dec    = 1'b0;
        load       = 1'b0;
        ld_sec     = '0;
        ld_min     = '0;
        ld_hour    = '0;
        mode_12h   = 1'b0;
`ifdef TIME_BASE_GEN_ALARM_EN
        al_hour = 5'd7;
        al_min  = 6'd30;
        al_arm  = 1'b0;
        al_ack  = 1'b0;
`endif

        vecs[0] = '{10, 20, 30, 0, 10, 20, 30, 10, 0};
        vecs[1] = '{0, 0, 0, 1, 0, 0, 0, 12, 0};
        vecs[2] = '{12, 5, 7, 1, 12, 5, 7, 12, 1};
        vecs[3] = '{13, 59, 59, 1, 13, 59, 59, 1, 1};
        vecs[4] = '{23, 0, 0, 1, 23, 0, 0, 11, 1};
        vecs[5] = '{11, 1, 2, 1, 11, 1, 2, 11, 0};
        vecs[6] = '{24, 60, 61, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{5, 60, 59, 0, 5, 0, 59, 5, 0};
        vecs[8] = '{23, 30, 0, 0, 23, 30, 0, 23, 1};
        vecs[9] = '{31, 12, 63, 1, 0, 12, 0, 12, 0};

        step(2);
        rst = 1'b0;
        checkTime("reset", 0, 0, 0);
        checkOutput("reset.sec_tick", int'(sec_tick), 0);
        checkOutput("reset.day_wrap", int'(day_wrap), 0);

        // First tick four cycles after reset release.
        step(3);
        checkOutput("pre_tick.sec", int'(sec), 0);
        checkOutput("pre_tick.sec_tick", int'(sec_tick), 0);
        step(1);
        checkOutput("first_tick.sec", int'(sec), 1);
        checkOutput("first_tick.sec_tick", int'(sec_tick), 1);
        step(1);
        checkOutput("first_tick.sec_tick_low", int'(sec_tick), 0);
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (sec_tick) ticks++;
        end
        checkOutput("tick_rate", ticks, 4);
        checkOutput("tick_rate.sec", int'(sec), 5);

        applyStimulus(0, 0, 59);
        step(4);
        checkTime("sec_carry", 0, 1, 0);

        // Day wrap from 23:59:58 over two ticks.
        applyStimulus(23, 59, 58);
        step(4);
        checkTime("dw_pre", 23, 59, 59);
        checkOutput("dw_pre.day_wrap", int'(day_wrap), 0);
        step(4);
        checkTime("dw", 0, 0, 0);
        checkOutput("dw.day_wrap", int'(day_wrap), 1);
        step(1);
        checkOutput("dw.day_wrap_low", int'(day_wrap), 0);

        // Adjust while paused; no carries, sec untouched.
        tick_en = 1'b0;
        applyStimulus(0, 0, 33);
        adj_dec = 1'b1;
        adj_min_p = 1'b1; step(1); adj_min_p = 1'b0;
        checkTime("adj_min_dec", 0, 59, 33);
        adj_hour_p = 1'b1; step(1); adj_hour_p = 1'b0;
        checkTime("adj_hour_dec", 23, 59, 33);
        adj_dec = 1'b0;
        adj_min_p = 1'b1; step(1); adj_min_p = 1'b0;
        checkTime("adj_min_inc", 23, 0, 33);
        adj_hour_p = 1'b1; step(1); adj_hour_p = 1'b0;
        checkTime("adj_hour_inc", 0, 0, 33);
        adj_min_p = 1'b1; adj_hour_p = 1'b1; step(1);
        adj_min_p = 1'b0; adj_hour_p = 1'b0;
        checkTime("adj_both", 0, 1, 33);

        // Load on the tick cycle: tick dropped, sec_tick kept, prescaler restarted.
        tick_en = 1'b1;
        applyStimulus(1, 2, 3);
        step(3);
        applyStimulus(10, 20, 30);
        checkTime("load_on_tick", 10, 20, 30);
        checkOutput("load_on_tick.sec_tick", int'(sec_tick), 1);
        step(3);
        checkOutput("load_presc0.sec", int'(sec), 30);
        step(1);
        checkOutput("load_presc0.next", int'(sec), 31);

        // Adjust on the tick cycle also drops the tick.
        step(3);
        adj_min_p = 1'b1; step(1); adj_min_p = 1'b0;
        checkTime("adj_on_tick", 10, 21, 31);
        checkOutput("adj_on_tick.sec_tick", int'(sec_tick), 1);

        // Pause for 20 cycles: nothing moves.
        tick_en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sec_tick) ticks++;
        end
        checkOutput("pause.ticks", ticks, 0);
        checkTime("pause", 10, 21, 31);

        // Table of loads checked through the display view.
        for (int i = 0; i < 10; i++) begin
            mode_12h = vecs[i].mode[0];
            applyStimulus(vecs[i].ldH, vecs[i].ldM, vecs[i].ldS);
            checkTime($sformatf("vec%0d", i), vecs[i].expH, vecs[i].expM, vecs[i].expS);
            checkOutput($sformatf("vec%0d.disp", i), int'(disp_hour), vecs[i].expDisp);
            checkOutput($sformatf("vec%0d.pm", i), int'(pm), vecs[i].expPm);
        end
        mode_12h = 1'b0;

        // Asynchronous reset mid-cycle.
        applyStimulus(12, 34, 56);
        #2;
        rst = 1'b1;
        #1;
        checkTime("async_rst", 0, 0, 0);
        step(1);
        rst = 1'b0;

`ifdef TIME_BASE_GEN_ALARM_EN
        tick_en = 1'b1;
        al_arm  = 1'b1;
        applyStimulus(7, 29, 59);
        checkOutput("al.load", int'(alarm_active), 0);
        step(4);
        checkTime("al.hit", 7, 30, 0);
        checkOutput("al.set", int'(alarm_active), 1);
        al_ack = 1'b1; step(1); al_ack = 1'b0;
        checkOutput("al.ack", int'(alarm_active), 0);
        tick_en = 1'b0;
        applyStimulus(7, 29, 0);
        adj_min_p = 1'b1; step(1); adj_min_p = 1'b0;
        checkTime("al.adj", 7, 30, 0);
        checkOutput("al.adj_no_set", int'(alarm_active), 0);
        applyStimulus(7, 30, 0);
        checkOutput("al.load_no_set", int'(alarm_active), 0);
        tick_en = 1'b1;
        applyStimulus(7, 29, 59);
        step(3);
        al_ack = 1'b1; step(1); al_ack = 1'b0;
        checkOutput("al.set_clear", int'(alarm_active), 0);
        applyStimulus(7, 29, 59);
        step(4);
        checkOutput("al.set2", int'(alarm_active), 1);
        al_arm = 1'b0; step(1);
        checkOutput("al.disarm", int'(alarm_active), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
